inst_fetch_responder: RTL and testbench
=======================================

// Module: inst_fetch_responder
// PURPOSE
// Responder end of the fetch interface. Takes the PC stage's rom_en/addr request and forwards it to an
// SRAM-like instruction bus (req/addr_ok/data_ok). Tracks outstanding requests and buffers returned words.
// Delivers {addr, inst} to the decode stage over a valid/ready handshake.
// On a taken branch (flush) it drops stale in-flight responses and clears buffered ones.
// PARAMETERS
// ADDR_W           32  request/bus address width
// DATA_W           32  instruction word width
// MAX_OUTSTANDING  2   max accepted-but-unreturned bus requests (1..4)
// FIFO_DEPTH       4   response buffer entries (>= MAX_OUTSTANDING)
// PORTS
// clk           in   1       clock, all state on posedge
// rst           in   1       asynchronous, active-low reset
// rom_en        in   1       fetch request valid from PC stage
// addr          in   ADDR_W  fetch address from PC stage
// flush         in   1       branch taken; discard all older fetches
// stall_req     out  1       request presented but not accepted this cycle; PC holds
// bus_req       out  1       instruction bus request
// bus_addr      out  ADDR_W  instruction bus address, word aligned
// bus_addr_ok   in   1       bus accepted request this cycle
// bus_data_ok   in   1       bus returns one word this cycle (in request order)
// bus_rdata     in   DATA_W  returned word
// inst_valid    out  1       inst/inst_addr valid toward decode
// inst_ready    in   1       decode consumes the word
// inst          out  DATA_W  instruction word
// inst_addr     out  ADDR_W  address of inst
// BEHAVIOUR
// - Reset (rst=0, async): outstanding count, tag queue and response FIFO empty; inst_valid=0, inst=0,
//   inst_addr=0. bus_req/stall_req are 0 while rst=0.
// - space = (outstanding < MAX_OUTSTANDING) && (outstanding + fifo_count < FIFO_DEPTH).
// - bus_req = rom_en && space, combinational. bus_addr = {addr[ADDR_W-1:2], 2'b00}.
// - accept = bus_req && bus_addr_ok. stall_req = rom_en && !accept.
// - On accept: push {addr, drop=0} to the tag queue; outstanding+1.
// - On bus_data_ok with a non-empty tag queue: pop the head; outstanding-1.
//   - drop=0: push {tag addr, bus_rdata} into the response FIFO.
//   - drop=1: discard the data.
// - bus_data_ok with an empty tag queue is ignored: no state change.
// - Accept and data_ok in the same cycle: outstanding is unchanged; the queue pushes and pops.
// - The response FIFO is registered. A word is visible on inst/inst_addr the cycle after data_ok.
//   - Minimum latency: accept at N, data_ok at N+1, inst_valid at N+2.
// - inst_valid = FIFO non-empty. Pop on inst_valid && inst_ready. Push and pop can happen in the same cycle.
// - flush (priority over push/pop):
//   - Sets drop=1 on every tag entry present before this cycle.
//   - Empties the response FIFO; inst_valid=0 next cycle.
//   - A data_ok arriving in the flush cycle is discarded.
//   - A request accepted in the flush cycle is the branch target and is kept (drop=0).
// - Reserving FIFO space at accept guarantees the FIFO never overflows. The bus may not stall data_ok.
// - Pointers wrap modulo depth; a full tag queue is impossible because accept is gated by space.
// - Reset mid-operation clears all state; later data_ok with an empty tag queue is ignored.
// TESTING
// 1 Bus zero-wait:
//   - Stimulus: rom_en=1, addr 0,4,8; addr_ok=1; data_ok one cycle after each accept.
//   - Response: inst_valid from cycle 2, inst_addr 0,4,8 in order, stall_req=0 throughout.
// 2 Outstanding limit:
//   - Stimulus: addr_ok=1, data_ok held 0.
//   - Response: exactly 2 accepts, then bus_req=0, stall_req=1.
//   - Then: one data_ok -> one more accept next cycle.
// 3 Backpressure:
//   - Stimulus: inst_ready=0.
//   - Response: FIFO holds 4 words; outstanding+fifo_count never exceeds 4; no word lost or duplicated.
//   - Then: inst_ready=1 drains in order.
// 4 Flush:
//   - Stimulus: 2 in flight (0x10, 0x14) and 1 buffered (0x0c); flush with rom_en=1, addr=0x80 accepted.
//   - Response: 0x0c cleared; data for 0x10 and 0x14 discarded; next inst_addr = 0x80.
// 5 Async reset mid-transfer:
//   - Stimulus: rst low mid-cycle with 2 outstanding; then a stray data_ok after release.
//   - Response: inst_valid=0 immediately; stray data_ok ignored; inst_valid stays 0.
// 6 Misaligned address:
//   - Stimulus: addr=0x1003.
//   - Response: bus_addr=0x1000; inst_addr=0x1003.

Source files
------------

// File: rtl/inst_fetch_responder.sv
// Fetch responder: forwards PC-stage fetches to an SRAM-like instruction bus,
// tracks outstanding requests and buffers returned words toward decode.
// Ports: clk, rst (async active-low); rom_en/addr/flush/stall_req (PC side);
// bus_req/bus_addr/bus_addr_ok/bus_data_ok/bus_rdata (bus side);
// inst_valid/inst_ready/inst/inst_addr (decode side).
module inst_fetch_responder #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic              flush,
  output logic              stall_req,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_addr
);

  localparam int TW = (MAX_OUTSTANDING > 1) ?
                      $clog2(MAX_OUTSTANDING) : 1;
  localparam int FW = (FIFO_DEPTH > 1) ?
                      $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + FIFO_DEPTH + 1);

  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  // tag queue: one entry per accepted, not yet returned request
  logic [ADDR_W-1:0]          tq_addr [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] tq_drop;
  logic [TW-1:0]              tq_wp;
  logic [TW-1:0]              tq_rp;
  logic [CW-1:0]              out_cnt;

  // response fifo toward decode
  logic [ADDR_W-1:0] f_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] f_data [FIFO_DEPTH];
  logic [FW-1:0]     f_wp;
  logic [FW-1:0]     f_rp;
  logic [CW-1:0]     f_cnt;

  logic space;
  logic accept;
  logic pop_tag;
  logic fpush;
  logic fpop;

  function automatic logic [TW-1:0] tinc(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
  endfunction

  function automatic logic [FW-1:0] finc(input logic [FW-1:0] p);
    return (p == FW'(FIFO_DEPTH - 1)) ? '0 : p + FW'(1);
  endfunction

  // fifo room is reserved at accept so returned data always fits
  assign space = (out_cnt < MAXO_C) &&
                 ((out_cnt + f_cnt) < DEPTH_C);

  assign bus_req   = rst && rom_en && space;
  assign bus_addr  = {addr[ADDR_W-1:2], 2'b00};
  assign accept    = bus_req && bus_addr_ok;
  assign stall_req = rst && rom_en && !accept;

  // empty tag queue means a stray data_ok; ignore it
  assign pop_tag = bus_data_ok && (out_cnt != '0);
  assign fpush   = pop_tag && !tq_drop[tq_rp] && !flush;
  assign fpop    = inst_valid && inst_ready && !flush;

  assign inst_valid = (f_cnt != '0);
  assign inst       = f_data[f_rp];
  assign inst_addr  = f_addr[f_rp];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_cnt <= '0;
      tq_wp   <= '0;
      tq_rp   <= '0;
      tq_drop <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++)
        tq_addr[i] <= '0;
    end else begin
      // older entries go stale; a same-cycle accept is the target
      if (flush)
        tq_drop <= '1;
      if (accept) begin
        tq_addr[tq_wp] <= addr;
        tq_drop[tq_wp] <= 1'b0;
        tq_wp          <= tinc(tq_wp);
      end
      if (pop_tag)
        tq_rp <= tinc(tq_rp);
      unique case (1'b1)
        accept && !pop_tag: out_cnt <= out_cnt + ONE_C;
        !accept && pop_tag: out_cnt <= out_cnt - ONE_C;
        default:            out_cnt <= out_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_wp  <= '0;
      f_rp  <= '0;
      f_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        f_addr[i] <= '0;
        f_data[i] <= '0;
      end
    end else if (flush) begin
      f_wp  <= '0;
      f_rp  <= '0;
      f_cnt <= '0;
    end else begin
      if (fpush) begin
        f_addr[f_wp] <= tq_addr[tq_rp];
        f_data[f_wp] <= bus_rdata;
        f_wp         <= finc(f_wp);
      end
      if (fpop)
        f_rp <= finc(f_rp);
      unique case (1'b1)
        fpush && !fpop: f_cnt <= f_cnt + ONE_C;
        !fpush && fpop: f_cnt <= f_cnt - ONE_C;
        default:        f_cnt <= f_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Testbench for inst_fetch_responder: directed scenarios plus random
// traffic checked against a queue-based reference model.
module tb_inst_fetch_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_en;
  logic [31:0] addr;
  logic        flush;
  logic        stall_req;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_addr;

  int checks = 0;
  int errors = 0;

  inst_fetch_responder dut (
    .clk        (clk),
    .rst        (rst),
    .rom_en     (rom_en),
    .addr       (addr),
    .flush      (flush),
    .stall_req  (stall_req),
    .bus_req    (bus_req),
    .bus_addr   (bus_addr),
    .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok),
    .bus_rdata  (bus_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_addr  (inst_addr)
  );

  always #5 clk = ~clk;

  // reference model: in-flight tags and buffered responses as queues
  typedef struct {
    logic [31:0] a;
    bit          drop;
  } tag_t;
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } rsp_t;

  tag_t tq[$];
  rsp_t rq[$];

  bit          e_req;
  bit          e_stall;
  bit          e_valid;
  logic [31:0] e_inst;
  logic [31:0] e_iaddr;
  logic [31:0] e_baddr;

  function automatic void model_eval();
    bit space;
    space   = (tq.size() < 2) && (tq.size() + rq.size() < 4);
    e_req   = rst && rom_en && space;
    e_stall = rst && rom_en && !(e_req && bus_addr_ok);
    e_valid = rq.size() > 0;
    e_inst  = e_valid ? rq[0].d : 32'h0;
    e_iaddr = e_valid ? rq[0].a : 32'h0;
    e_baddr = addr & 32'hFFFF_FFFC;
  endfunction

  function automatic void model_step();
    tag_t t;
    rsp_t r;
    bit   acc;
    model_eval();
    acc = e_req && bus_addr_ok;
    if (!rst) begin
      tq.delete();
      rq.delete();
      return;
    end
    if (flush) begin
      foreach (tq[i]) tq[i].drop = 1'b1;
      rq.delete();
    end else if (rq.size() > 0 && inst_ready) begin
      void'(rq.pop_front());
    end
    if (bus_data_ok && tq.size() > 0) begin
      t = tq.pop_front();
      if (!t.drop && !flush) begin
        r.a = t.a;
        r.d = bus_rdata;
        rq.push_back(r);
      end
    end
    if (acc) begin
      t.a    = addr;
      t.drop = 1'b0;
      tq.push_back(t);
    end
  endfunction

  task automatic drive(input bit re, input logic [31:0] a,
                       input bit aok, input bit dok,
                       input bit rdy, input bit fl);
    rom_en      = re;
    addr        = a;
    bus_addr_ok = aok;
    bus_data_ok = dok;
    inst_ready  = rdy;
    flush       = fl;
    bus_rdata   = $urandom;
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((tq.size() > 0 || rq.size() > 0) && n < 30) begin
      drive(1'b0, 32'h0, 1'b0, tq.size() > 0, 1'b1, 1'b0);
      advance();
      n++;
    end
    checks++;
    if (tq.size() > 0 || rq.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout tags=%0d rsp=%0d want 0 0",
               tq.size(), rq.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    #3;
    checks++;
    if ({bus_req, stall_req, inst_valid} !== 3'b000) begin
      errors++;
      $display("FAIL rst_ctrl got %b want 000",
               {bus_req, stall_req, inst_valid});
    end
    checks++;
    if (inst !== 32'h0 || inst_addr !== 32'h0) begin
      errors++;
      $display("FAIL rst_data got %h/%h want 0/0", inst, inst_addr);
    end
    @(posedge clk);
    model_step();
    #1;
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #4;
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_release_valid got %b want 0", inst_valid);
    end
    advance();
  endtask

  task automatic test_zero_wait();
    logic [31:0] got[$];
    bit          re[6]  = '{1, 1, 1, 0, 0, 0};
    bit          dok[6] = '{0, 1, 1, 1, 0, 0};
    logic [31:0] pc;
    pc = 32'h0;
    for (int c = 0; c < 6; c++) begin
      drive(re[c], pc, 1'b1, dok[c], 1'b1, 1'b0);
      #4;
      model_eval();
      checks++;
      if ({bus_req, stall_req, inst_valid} !==
          {e_req, e_stall, e_valid}) begin
        errors++;
        $display("FAIL zw_ctrl c=%0d got %b want %b", c,
                 {bus_req, stall_req, inst_valid},
                 {e_req, e_stall, e_valid});
      end
      if (e_valid) begin
        checks++;
        if ({inst_addr, inst} !== {e_iaddr, e_inst}) begin
          errors++;
          $display("FAIL zw_data c=%0d got %h/%h want %h/%h", c,
                   inst_addr, inst, e_iaddr, e_inst);
        end
      end
      if (c == 2) begin
        checks++;
        if (inst_valid !== 1'b1 || inst_addr !== 32'h0) begin
          errors++;
          $display("FAIL zw_latency got v=%b a=%h want v=1 a=0",
                   inst_valid, inst_addr);
        end
      end
      if (inst_valid && inst_ready) got.push_back(inst_addr);
      if (e_req) pc += 4;
      advance();
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL zw_count got %0d want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== 32'(4 * i)) begin
          errors++;
          $display("FAIL zw_order i=%0d got %h want %h",
                   i, got[i], 4 * i);
        end
      end
    end
  endtask

  task automatic test_outstanding();
    int          accs;
    logic [31:0] pc;
    bit          dok;
    accs = 0;
    pc   = 32'h100;
    for (int c = 0; c < 6; c++) begin
      dok = (c == 4);
      drive(1'b1, pc, 1'b1, dok, 1'b1, 1'b0);
      #4;
      model_eval();
      checks++;
      if ({bus_req, stall_req, inst_valid} !==
          {e_req, e_stall, e_valid}) begin
        errors++;
        $display("FAIL os_ctrl c=%0d got %b want %b", c,
                 {bus_req, stall_req, inst_valid},
                 {e_req, e_stall, e_valid});
      end
      if (c < 4 && bus_req && bus_addr_ok) accs++;
      if (c == 3 || c == 4) begin
        checks++;
        if (bus_req !== 1'b0 || stall_req !== 1'b1) begin
          errors++;
          $display("FAIL os_limit c=%0d got req=%b stall=%b want 0 1",
                   c, bus_req, stall_req);
        end
      end
      if (c == 5) begin
        checks++;
        if (bus_req !== 1'b1 || stall_req !== 1'b0) begin
          errors++;
          $display("FAIL os_refill got req=%b stall=%b want 1 0",
                   bus_req, stall_req);
        end
      end
      if (e_req) pc += 4;
      advance();
    end
    checks++;
    if (accs != 2) begin
      errors++;
      $display("FAIL os_accepts got %0d want 2", accs);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    logic [31:0] pc;
    pc = 32'h200;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, pc, 1'b1, 1'b1, 1'b0, 1'b0);
      #4;
      model_eval();
      checks++;
      if ({bus_req, stall_req, inst_valid} !==
          {e_req, e_stall, e_valid}) begin
        errors++;
        $display("FAIL bp_ctrl c=%0d got %b want %b", c,
                 {bus_req, stall_req, inst_valid},
                 {e_req, e_stall, e_valid});
      end
      if (e_req) pc += 4;
      advance();
    end
    checks++;
    if (pc !== 32'h210) begin
      errors++;
      $display("FAIL bp_accepts got %0d want 4", (pc - 32'h200) / 4);
    end
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      #4;
      model_eval();
      if (e_valid) begin
        checks++;
        if ({inst_addr, inst} !== {e_iaddr, e_inst}) begin
          errors++;
          $display("FAIL bp_data c=%0d got %h/%h want %h/%h", c,
                   inst_addr, inst, e_iaddr, e_inst);
        end
      end
      if (inst_valid) got.push_back(inst_addr);
      advance();
    end
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("FAIL bp_count got %0d want 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== 32'h200 + 32'(4 * i)) begin
          errors++;
          $display("FAIL bp_order i=%0d got %h want %h",
                   i, got[i], 32'h200 + 4 * i);
        end
      end
    end
  endtask

  typedef struct {
    bit          re;
    logic [31:0] a;
    bit          dok;
    bit          fl;
    bit          rdy;
    int          xv;
    logic [31:0] xa;
  } fstep_t;

  task automatic test_flush();
    fstep_t fs[12];
    fs[0]  = '{1'b1, 32'h0c, 1'b0, 1'b0, 1'b0, 2, 32'h0};
    fs[1]  = '{1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 2, 32'h0};
    fs[2]  = '{1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 1, 32'h0c};
    fs[3]  = '{1'b1, 32'h80, 1'b1, 1'b1, 1'b0, 1, 32'h0c};
    fs[4]  = '{1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 0, 32'h0};
    fs[5]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 0, 32'h0};
    fs[6]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1, 32'h80};
    fs[7]  = '{1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 0, 32'h0};
    fs[8]  = '{1'b1, 32'h84, 1'b0, 1'b1, 1'b1, 0, 32'h0};
    fs[9]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 0, 32'h0};
    fs[10] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 0, 32'h0};
    fs[11] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1, 32'h84};
    for (int c = 0; c < 12; c++) begin
      drive(fs[c].re, fs[c].a, 1'b1, fs[c].dok, fs[c].rdy, fs[c].fl);
      #4;
      model_eval();
      checks++;
      if ({bus_req, stall_req, inst_valid} !==
          {e_req, e_stall, e_valid}) begin
        errors++;
        $display("FAIL fl_ctrl c=%0d got %b want %b", c,
                 {bus_req, stall_req, inst_valid},
                 {e_req, e_stall, e_valid});
      end
      if (fs[c].xv != 2) begin
        checks++;
        if (inst_valid !== fs[c].xv[0] ||
            (fs[c].xv == 1 && inst_addr !== fs[c].xa)) begin
          errors++;
          $display("FAIL fl_seq c=%0d got v=%b a=%h want v=%0d a=%h",
                   c, inst_valid, inst_addr, fs[c].xv, fs[c].xa);
        end
      end
      advance();
    end
    drain();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h3c, 1'b1, 1'b0, 1'b0, 1'b0);
    advance();
    drive(1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0);
    advance();
    drive(1'b1, 32'h44, 1'b1, 1'b0, 1'b0, 1'b0);
    advance();
    drive(1'b1, 32'h48, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL ar_pre_valid got %b want 1", inst_valid);
    end
    #1;
    rst = 1'b0;
    tq.delete();
    rq.delete();
    #1;
    checks++;
    if ({bus_req, stall_req, inst_valid} !== 3'b000) begin
      errors++;
      $display("FAIL ar_ctrl got %b want 000",
               {bus_req, stall_req, inst_valid});
    end
    checks++;
    if (inst !== 32'h0 || inst_addr !== 32'h0) begin
      errors++;
      $display("FAIL ar_data got %h/%h want 0/0", inst, inst_addr);
    end
    @(posedge clk);
    model_step();
    #3;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
      if (c == 0) #2;
      else #4;
      checks++;
      if (inst_valid !== 1'b0 || bus_req !== 1'b0) begin
        errors++;
        $display("FAIL ar_stray c=%0d got v=%b req=%b want 0 0",
                 c, inst_valid, bus_req);
      end
      advance();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    #4;
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL ar_after got %b want 0", inst_valid);
    end
    advance();
  endtask

  task automatic test_misaligned();
    drive(1'b1, 32'h1003, 1'b1, 1'b0, 1'b1, 1'b0);
    #4;
    checks++;
    if (bus_addr !== 32'h1000 || bus_req !== 1'b1) begin
      errors++;
      $display("FAIL mis_busaddr got %h req=%b want 1000 1",
               bus_addr, bus_req);
    end
    advance();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    advance();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    #4;
    model_eval();
    checks++;
    if (inst_valid !== 1'b1 || inst_addr !== 32'h1003 ||
        inst !== e_inst) begin
      errors++;
      $display("FAIL mis_inst got v=%b a=%h d=%h want 1 1003 %h",
               inst_valid, inst_addr, inst, e_inst);
    end
    advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(9, 0) < 7, $urandom & 32'hFFFF,
            $urandom_range(9, 0) < 6, $urandom_range(1, 0) == 1,
            $urandom_range(9, 0) < 6, $urandom_range(19, 0) == 0);
      #4;
      model_eval();
      checks++;
      if ({bus_req, stall_req, inst_valid} !==
          {e_req, e_stall, e_valid}) begin
        errors++;
        $display("FAIL rnd_ctrl c=%0d got %b want %b", c,
                 {bus_req, stall_req, inst_valid},
                 {e_req, e_stall, e_valid});
      end
      checks++;
      if (bus_addr !== e_baddr) begin
        errors++;
        $display("FAIL rnd_busaddr c=%0d got %h want %h",
                 c, bus_addr, e_baddr);
      end
      if (e_valid) begin
        checks++;
        if ({inst_addr, inst} !== {e_iaddr, e_inst}) begin
          errors++;
          $display("FAIL rnd_data c=%0d got %h/%h want %h/%h", c,
                   inst_addr, inst, e_iaddr, e_inst);
        end
      end
      advance();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_outstanding();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_misaligned();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
